// File: rtl/disp_pkg.sv
// Shared types, glyph constants and width helpers for the display scan controller.
package disp_pkg;

  typedef enum logic {
    StShow = 1'b0,
    StGap  = 1'b1
  } state_e;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Bits needed to hold 0..n-1, never less than one
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder; 10-15 show a dash.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Glyph lookup
  always_comb begin
    seg_n = SEG_DASH;
    case (nibble)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with leading-zero blanking and
// frame-synchronous value update. Optional blink support: DISP_SCAN_BLINK_EN.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 6,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES   = 500
`ifdef DISP_SCAN_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 250
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load_valid,
  output logic                  load_ready,
`ifdef DISP_SCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_mask,
`endif
  output logic [N_DIGITS-1:0]   digit_sel_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_start
);

  localparam int unsigned IdxW   = cnt_width(N_DIGITS);
  localparam int unsigned CntMax = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = cnt_width(CntMax);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(N_DIGITS - 1);
  localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);

  state_e                state_q;
  logic [IdxW-1:0]       idx_q, next_idx;
  logic [CntW-1:0]       cnt_q;
  logic                  boundary, accept;

  logic [4*N_DIGITS-1:0] active_bcd_q, active_bcd_d, shadow_bcd_q, shadow_bcd_d;
  logic [N_DIGITS-1:0]   active_dp_q, active_dp_d, shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;

  logic [N_DIGITS-1:0]   blank;
  logic [3:0]            nib_sel;
  logic                  dp_sel, blank_sel, blink_sel, zero_run;
  logic [6:0]            dec_seg_n, show_seg_n;
  logic                  show_dp_n;

  // The GAP->SHOW edge that wraps back to digit 0 is the only point values change
  assign boundary = (state_q == StGap) && (cnt_q == '0) && (idx_q == IdxLast);
  assign next_idx = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
  assign accept   = load_valid & load_ready;

  // Handshake: stage into shadow mid-frame, promote or bypass at the boundary
  always_comb begin
    active_bcd_d = active_bcd_q;
    active_dp_d  = active_dp_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    if (boundary) begin
      if (pending_q) begin
        active_bcd_d = shadow_bcd_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
      end else if (accept) begin
        active_bcd_d = bcd_in;
        active_dp_d  = dp_in;
      end
    end else if (accept) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end
  end

  // Data registers and ready flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_bcd_q <= '0;
      active_dp_q  <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      load_ready   <= 1'b1;
    end else begin
      active_bcd_q <= active_bcd_d;
      active_dp_q  <= active_dp_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      load_ready   <= ~pending_d;
    end
  end

`ifdef DISP_SCAN_BLINK_EN
  localparam int unsigned FrmW = cnt_width(BLINK_FRAMES);
  logic [FrmW-1:0] frm_cnt_q;
  logic            phase_q, phase_d;

  assign phase_d = phase_q ^ (boundary && (frm_cnt_q == FrmW'(BLINK_FRAMES - 1)));

  // Blink phase flips once every BLINK_FRAMES frame boundaries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frm_cnt_q <= '0;
      phase_q   <= 1'b1;
    end else if (boundary) begin
      frm_cnt_q <= (frm_cnt_q == FrmW'(BLINK_FRAMES - 1)) ? '0 : frm_cnt_q + 1'b1;
      phase_q   <= phase_d;
    end
  end
`endif

  // Blanking chain from the MSD down, then select the digit about to be shown.
  // Uses the next-state value so a boundary update is visible on digit 0 at once.
  always_comb begin
    blank     = '0;
    zero_run  = 1'b1;
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    blink_sel = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (active_bcd_d[4*i +: 4] == 4'h0) && !active_dp_d[i];
      blank[i] = zero_run;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (next_idx == IdxW'(i)) begin
        nib_sel   = active_bcd_d[4*i +: 4];
        dp_sel    = active_dp_d[i];
        blank_sel = blank[i];
`ifdef DISP_SCAN_BLINK_EN
        blink_sel = ~phase_d & blink_mask[i];
`endif
      end
    end
  end

  seg7_decode u_dec (
    .nibble (nib_sel),
    .seg_n  (dec_seg_n)
  );

  assign show_seg_n = (blank_sel || blink_sel) ? SEG_OFF : dec_seg_n;
  assign show_dp_n  = ~(dp_sel & ~blink_sel);

  // Scan FSM; outputs are latched on entry to each state and held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StGap;
      idx_q       <= IdxLast;
      cnt_q       <= '0;
      digit_sel_n <= '1;
      seg_n       <= SEG_OFF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (state_q == StShow) begin
        state_q     <= StGap;
        cnt_q       <= GapLoad;
        digit_sel_n <= '1;
        seg_n       <= SEG_OFF;
        dp_n        <= 1'b1;
      end else begin
        state_q     <= StShow;
        cnt_q       <= DwellLoad;
        idx_q       <= next_idx;
        digit_sel_n <= ~(N_DIGITS'(1) << next_idx);
        seg_n       <= show_seg_n;
        dp_n        <= show_dp_n;
        frame_start <= boundary;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: directed steps plus random loads, every
// cycle compared against a frame-position reference model.
module tb_disp_scan_ctrl;

  localparam int ND   = 4;
  localparam int DW   = 4;
  localparam int GP   = 1;
  localparam int SLOT = DW + GP;
  localparam int FL   = ND * SLOT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  digit_sel_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  logic [6:0]  glyph [16];
  int          e;
  logic [15:0] m_act_bcd, m_sh_bcd;
  logic [3:0]  m_act_dp, m_sh_dp;
  bit          m_pend, m_ready;

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .N_DIGITS     (ND),
    .DWELL_CYCLES (DW),
    .GAP_CYCLES   (GP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bcd_in      (bcd_in),
    .dp_in       (dp_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
`ifdef DISP_SCAN_BLINK_EN
    .blink_mask  (4'b0000),
`endif
    .digit_sel_n (digit_sel_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s @edge %0d: got %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic model_reset();
    e         = -1;
    m_act_bcd = '0;
    m_act_dp  = '0;
    m_sh_bcd  = '0;
    m_sh_dp   = '0;
    m_pend    = 1'b0;
    m_ready   = 1'b1;
  endtask

  task automatic check_reset();
    chk("rst_sel", 32'(digit_sel_n), 32'hF);
    chk("rst_seg", 32'(seg_n), 32'h7F);
    chk("rst_dp", 32'(dp_n), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
  endtask

  // One clock: drive inputs, advance the model, check all outputs after the edge
  task automatic tick(input bit v, input logic [15:0] b, input logic [3:0] d);
    int          p, dg;
    bit          show, blank, acc;
    logic [3:0]  nib;
    logic [3:0]  exp_sel;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    load_valid = v;
    bcd_in     = b;
    dp_in      = d;
    @(posedge clk);
    e++;
    acc = v && m_ready;
    if (e % FL == 0) begin
      if (m_pend) begin
        m_act_bcd = m_sh_bcd;
        m_act_dp  = m_sh_dp;
        m_pend    = 1'b0;
      end else if (acc) begin
        m_act_bcd = b;
        m_act_dp  = d;
      end
    end else if (acc) begin
      m_sh_bcd = b;
      m_sh_dp  = d;
      m_pend   = 1'b1;
    end
    m_ready = !m_pend;
    #1;
    p     = e % FL;
    dg    = p / SLOT;
    show  = (p % SLOT) < DW;
    nib   = m_act_bcd[4*dg +: 4];
    // A digit is blank when it and everything above it is zero with no dp
    blank = (dg != 0) && ((m_act_bcd >> (4 * dg)) == 16'h0) && ((m_act_dp >> dg) == 4'h0);
    exp_sel = show ? ~(4'b0001 << dg) : 4'hF;
    exp_seg = (show && !blank) ? glyph[nib] : 7'h7F;
    exp_dp  = show ? ~m_act_dp[dg] : 1'b1;
    chk("digit_sel_n", 32'(digit_sel_n), 32'(exp_sel));
    chk("seg_n", 32'(seg_n), 32'(exp_seg));
    chk("dp_n", 32'(dp_n), 32'(exp_dp));
    chk("frame_start", 32'(frame_start), 32'(p == 0));
    chk("load_ready", 32'(load_ready), 32'(m_ready));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 16'h0, 4'h0);
  endtask

  // Idle until the next edge lands at frame position s with the model ready
  task automatic wait_slot(input int s);
    for (int k = 0; k < 3 * FL; k++) begin
      if (m_ready && ((e + 1) % FL == s)) break;
      tick(1'b0, 16'h0, 4'h0);
    end
  endtask

  initial begin
    logic [15:0] rb;
    logic [3:0]  rd;
    int          hold;
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    reset_n    = 1'b0;
    load_valid = 1'b0;
    bcd_in     = '0;
    dp_in      = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset();
    reset_n = 1'b1;

    // Reset release: one frame of "0" on digit 0 only
    idle(FL);

    // Mid-frame load of 0305
    idle(7);
    tick(1'b1, 16'h0305, 4'b0000);
    idle(2 * FL);

    // All zero with dp on digit 2
    wait_slot(8);
    tick(1'b1, 16'h0000, 4'b0100);
    idle(2 * FL);

    // Dash in the MSD keeps lower zeros lit
    wait_slot(3);
    tick(1'b1, 16'hA001, 4'b0000);
    idle(2 * FL);

    // Load on the boundary cycle itself goes straight to the new frame
    wait_slot(0);
    tick(1'b1, 16'h1234, 4'b0000);
    idle(FL + 2);

    // Reset mid-frame with a value pending
    wait_slot(6);
    tick(1'b1, 16'h9876, 4'b1010);
    idle(3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(FL + 5);

    // Random loads with held valid and sparse nonzero nibbles
    for (int it = 0; it < 40; it++) begin
      idle($urandom_range(0, 25));
      for (int j = 0; j < 4; j++)
        rb[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      rd   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) tick(1'b1, rb, rd);
    end
    idle(2 * FL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
